sim_result_uart_tx: RTL and testbench

- Consumer end of the circuit-simulator output bus: takes a snapshot of the simulator result outputs (out1, out2, out3, out4, out5) on request.
- Serializes the snapshot as a framed byte packet over an 8N1 UART line to the host PC.
- Sits between the simulated-circuit core and the Elbert board's TX pin.
- Mirrors the stimulus side: the core produces results, this block reads and ships them.

---
 rtl/sim_result_uart_tx.sv | 162 ++++++++++++++++
 tb/tb_sim_result_uart_tx.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_result_uart_tx.sv
// Snapshots simulator results and ships them as a framed 8N1 UART packet.
// Define SIM_RESULT_CHECKSUM_EN to append an XOR checksum byte.
module sim_result_uart_tx #(
  parameter int         CLKS_PER_BIT = 104,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        out1,
  input  logic [15:0] out2,
  input  logic [31:0] out3,
  input  logic [15:0] out4,
  input  logic [15:0] out5,
  output logic        tx,
  output logic        busy,
  output logic        done
);

`ifdef SIM_RESULT_CHECKSUM_EN
  localparam int NB = 13;
`else
  localparam int NB = 12;
`endif
  localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_BYTE = 4'(NB - 1);

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } state_t;

  state_t      state_q, state_d;
  logic [80:0] snap_q, snap_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  cur_byte;
  logic [2:0]  next_bit;

`ifdef SIM_RESULT_CHECKSUM_EN
  logic [7:0] csum;
  assign csum = {7'b0, snap_q[80]}
              ^ snap_q[79:72] ^ snap_q[71:64]
              ^ snap_q[63:56] ^ snap_q[55:48]
              ^ snap_q[47:40] ^ snap_q[39:32]
              ^ snap_q[31:24] ^ snap_q[23:16]
              ^ snap_q[15:8]  ^ snap_q[7:0];
`endif

  // Snapshot layout: {out1, out2, out3, out4, out5}
  always_comb begin
    cur_byte = HEADER;
    case (byte_idx_q)
      4'd1:    cur_byte = {7'b0, snap_q[80]};
      4'd2:    cur_byte = snap_q[79:72];
      4'd3:    cur_byte = snap_q[71:64];
      4'd4:    cur_byte = snap_q[63:56];
      4'd5:    cur_byte = snap_q[55:48];
      4'd6:    cur_byte = snap_q[47:40];
      4'd7:    cur_byte = snap_q[39:32];
      4'd8:    cur_byte = snap_q[31:24];
      4'd9:    cur_byte = snap_q[23:16];
      4'd10:   cur_byte = snap_q[15:8];
      4'd11:   cur_byte = snap_q[7:0];
`ifdef SIM_RESULT_CHECKSUM_EN
      4'd12:   cur_byte = csum;
`endif
      default: cur_byte = HEADER;
    endcase
  end

  assign next_bit = bit_idx_q + 3'd1;

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    cnt_d      = cnt_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    if (state_q == IDLE) begin
      tx_d   = 1'b1;
      busy_d = 1'b0;
      if (start) begin
        snap_d     = {out1, out2, out3, out4, out5};
        busy_d     = 1'b1;
        tx_d       = 1'b0;
        state_d    = START_BIT;
        byte_idx_d = 4'd0;
        bit_idx_d  = 3'd0;
        cnt_d      = 16'd0;
      end
    end else if (cnt_q != LAST_CNT) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = 16'd0;
      case (state_q)
        START_BIT: begin
          tx_d      = cur_byte[0];
          bit_idx_d = 3'd0;
          state_d   = DATA_BITS;
        end
        DATA_BITS: begin
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP_BIT;
          end else begin
            bit_idx_d = next_bit;
            tx_d      = cur_byte[next_bit];
          end
        end
        STOP_BIT: begin
          if (byte_idx_q == LAST_BYTE) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
            tx_d       = 1'b0;
            state_d    = START_BIT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      cnt_q      <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      cnt_q      <= cnt_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_sim_result_uart_tx.sv
// Scoreboard bench: expected bytes queued at launch, popped by a UART decoder.
// Honours SIM_RESULT_CHECKSUM_EN for packet length and checksum byte.
module tb_sim_result_uart_tx;
  localparam int N = 4;
`ifdef SIM_RESULT_CHECKSUM_EN
  localparam int NB = 13;
`else
  localparam int NB = 12;
`endif
  localparam int PKT_CYC = NB * 10 * N;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        out1 = 1'b0;
  logic [15:0] out2 = '0;
  logic [31:0] out3 = '0;
  logic [15:0] out4 = '0;
  logic [15:0] out5 = '0;
  logic        tx, busy, done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int rx_cnt = 0;
  int lat = 0;
  bit busy_ok;
  bit hit;
  logic [7:0] exp_q[$];

  sim_result_uart_tx #(.CLKS_PER_BIT(N), .HEADER(8'hA5)) dut (
    .clock(clk), .reset(rst), .start(start),
    .out1(out1), .out2(out2), .out3(out3),
    .out4(out4), .out5(out5),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // UART decoder: samples half a clock into each bit
  initial begin : decoder
    logic prev;
    logic [7:0] b;
    logic stp;
    bit ok;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0 && prev === 1'b1) begin
        ok = 1;
        for (int i = 0; i < 8; i++) begin
          repeat (N) begin
            @(negedge clk);
            if (rst) ok = 0;
          end
          b[i] = tx;
        end
        repeat (N) begin
          @(negedge clk);
          if (rst) ok = 0;
        end
        stp = tx;
        if (ok) begin
          rx_cnt++;
          total++;
          if (stp !== 1'b1) begin
            bad++;
            $display("FAIL stop_bit got=%b want=1", stp);
          end
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_byte got=%h want=none", b);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (b !== e) begin
              bad++;
              $display("FAIL rx_byte got=%h want=%h", b, e);
            end
          end
        end
      end
      prev = tx;
    end
  end

  task automatic push_pkt(input logic o1, input logic [15:0] o2,
                          input logic [31:0] o3, input logic [15:0] o4,
                          input logic [15:0] o5);
    logic [7:0] b[13];
    logic [7:0] cs;
    b[0] = 8'hA5;
    b[1] = {7'b0, o1};
    b[2] = o2[15:8];  b[3] = o2[7:0];
    b[4] = o3[31:24]; b[5] = o3[23:16];
    b[6] = o3[15:8];  b[7] = o3[7:0];
    b[8] = o4[15:8];  b[9] = o4[7:0];
    b[10] = o5[15:8]; b[11] = o5[7:0];
    cs = 8'h00;
    for (int i = 1; i < 12; i++) cs ^= b[i];
    b[12] = cs;
    for (int i = 0; i < NB; i++) exp_q.push_back(b[i]);
  endtask

  task automatic set_outs(input logic o1, input logic [15:0] o2,
                          input logic [31:0] o3, input logic [15:0] o4,
                          input logic [15:0] o5);
    out1 = o1; out2 = o2; out3 = o3; out4 = o4; out5 = o5;
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc + 1;
    push_pkt(out1, out2, out3, out4, out5);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Leaves the caller at the negedge where done is seen
  task automatic wait_done();
    int k;
    busy_ok = 1;
    hit = 0;
    k = 0;
    while (!hit && k < 3000) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) hit = 1;
      else if (busy !== 1'b1) busy_ok = 0;
    end
    lat = cyc - start_cyc;
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL done_timeout got=none want=done");
    end
  endtask

  task automatic test_reset();
    bit stay;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({tx, busy, done} !== 3'b100) begin
      bad++;
      $display("FAIL reset_state got=%b want=100", {tx, busy, done});
    end
    stay = 1;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) stay = 0;
    end
    total++;
    if (!stay) begin
      bad++;
      $display("FAIL idle_hold got=0 want=1");
    end
  endtask

  task automatic test_single();
    int d0, r0;
    d0 = done_cnt;
    r0 = rx_cnt;
    set_outs(1'b1, 16'h1234, 32'hDEADBEEF, 16'h00FF, 16'h8001);
    launch();
    wait_done();
    total++;
    if (lat != PKT_CYC) begin
      bad++;
      $display("FAIL single_latency got=%0d want=%0d", lat, PKT_CYC);
    end
    total++;
    if (!busy_ok) begin
      bad++;
      $display("FAIL single_busy got=0 want=1");
    end
    repeat (20) @(negedge clk);
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL single_done_count got=%0d want=1", done_cnt - d0);
    end
    total++;
    if (rx_cnt - r0 != NB || exp_q.size() != 0) begin
      bad++;
      $display("FAIL single_bytes got=%0d want=%0d", rx_cnt - r0, NB);
    end
  endtask

  task automatic test_snapshot();
    int d0, r0;
    d0 = done_cnt;
    r0 = rx_cnt;
    set_outs(1'b1, 16'h1234, 32'hDEADBEEF, 16'h00FF, 16'h8001);
    launch();
    repeat (49) @(negedge clk);
    set_outs(1'b0, 16'h0, 32'h0, 16'h0, 16'h0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    total++;
    if (lat != PKT_CYC) begin
      bad++;
      $display("FAIL snap_latency got=%0d want=%0d", lat, PKT_CYC);
    end
    repeat (PKT_CYC / 2) @(negedge clk);
    total++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL snap_done_count got=%0d want=1", done_cnt - d0);
    end
    total++;
    if (rx_cnt - r0 != NB || exp_q.size() != 0) begin
      bad++;
      $display("FAIL snap_bytes got=%0d want=%0d", rx_cnt - r0, NB);
    end
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = rx_cnt;
    set_outs(1'b0, 16'h7FFF, 32'h0123_4567, 16'hCAFE, 16'h5A5A);
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc + 1;
    push_pkt(out1, out2, out3, out4, out5);
    wait_done();
    total++;
    if (lat != PKT_CYC) begin
      bad++;
      $display("FAIL b2b_lat1 got=%0d want=%0d", lat, PKT_CYC);
    end
    total++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_gap got=%b%b want=10", tx, busy);
    end
    out2 = out2 + 16'd1;
    push_pkt(out1, out2, out3, out4, out5);
    @(negedge clk);
    start_cyc = cyc;
    start = 1'b0;
    total++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_restart got=%b%b want=01", tx, busy);
    end
    wait_done();
    total++;
    if (lat != PKT_CYC) begin
      bad++;
      $display("FAIL b2b_lat2 got=%0d want=%0d", lat, PKT_CYC);
    end
    repeat (20) @(negedge clk);
    total++;
    if (rx_cnt - r0 != 2 * NB || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_bytes got=%0d want=%0d", rx_cnt - r0, 2 * NB);
    end
  endtask

  task automatic test_reset_mid();
    int d0, r0, k;
    d0 = done_cnt;
    r0 = rx_cnt;
    set_outs(1'b1, 16'hBEEF, 32'hF00D_0042, 16'h1357, 16'h2468);
    launch();
    k = 0;
    while (rx_cnt - r0 < 5 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    repeat (2 * N) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({tx, busy, done} !== 3'b100) begin
      bad++;
      $display("FAIL mid_reset got=%b want=100", {tx, busy, done});
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (PKT_CYC) @(negedge clk);
    total++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_no_done got=%0d want=0", done_cnt - d0);
    end
    r0 = rx_cnt;
    set_outs(1'b0, 16'h0F0F, 32'h8000_0001, 16'hFFFF, 16'h00A5);
    launch();
    wait_done();
    total++;
    if (lat != PKT_CYC) begin
      bad++;
      $display("FAIL post_latency got=%0d want=%0d", lat, PKT_CYC);
    end
    repeat (20) @(negedge clk);
    total++;
    if (rx_cnt - r0 != NB || exp_q.size() != 0) begin
      bad++;
      $display("FAIL post_bytes got=%0d want=%0d", rx_cnt - r0, NB);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_snapshot();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
